ntt_out_collector: RTL and testbench

// - Consumes the dual-lane stream (out_en, out[2]) leaving the last ntt stage; one coefficient pair per enabled beat.
// - Writes each frame of 2^N_LOG coefficients into a ping-pong buffer, undoing the bit-reversed output order.
// - Serves a random-access read port (1-cycle latency) so the next frame can stream in while the previous one is read.

---
 rtl/ntt_out_collector_pkg.sv | 22 ++
 rtl/ntt_out_collector_coef_ram.sv | 39 +++
 rtl/ntt_out_collector.sv | 154 +++++++++++++++
 tb/tb_ntt_out_collector.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/ntt_out_collector_pkg.sv
// Shared types and helpers for the NTT output collector: bank lifecycle
// states and the bit-reversal used to undo the pipeline's output order.
package ntt_out_collector_pkg;

  typedef enum logic [1:0] {
    EMPTY   = 2'd0,
    FILLING = 2'd1,
    FULL    = 2'd2
  } bank_state_t;

  localparam int N_LOG_DEFAULT = 8;
  localparam int W_DEFAULT     = 12;
  localparam int FRAME_BEATS   = 1 << (N_LOG_DEFAULT - 1);

  // Reverse the low n bits of x (n <= 16); bits above n come back as zero.
  function automatic logic [15:0] bitrev(input logic [15:0] x, input int n);
    logic [15:0] rev;
    rev = {<<{x}};
    return rev >> (16 - n);
  endfunction

endpackage

// File: rtl/ntt_out_collector_coef_ram.sv
// One half of one ping-pong bank: simple 1W1R synchronous RAM whose read
// register holds its value until the next enabled read.
module ntt_out_collector_coef_ram
  import ntt_out_collector_pkg::*;
#(
  parameter int AW = 7,
  parameter int W  = 12
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);

  logic [W-1:0] mem [2**AW];
  logic [W-1:0] rdata_q, rdata_d;

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  always_comb begin
    rdata_d = rdata_q;
    if (re) rdata_d = mem[raddr];
  end

  // Only the output register is reset, so rd_data reads 0 out of reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) rdata_q <= '0;
    else     rdata_q <= rdata_d;
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/ntt_out_collector.sv
// Collects the dual-lane NTT output stream into a ping-pong buffer in
// natural coefficient order and serves it through a 1-cycle read port.
module ntt_out_collector
  import ntt_out_collector_pkg::*;
#(
  parameter int N_LOG  = N_LOG_DEFAULT,
  parameter int W      = W_DEFAULT,
  parameter int BITREV = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_en,
  input  logic [1:0][W-1:0]     in,
  output logic                  in_rdy,
  output logic                  frm_done,
  output logic                  ovf,
  output logic                  rd_avail,
  input  logic                  rd_en,
  input  logic [N_LOG-1:0]      rd_addr,
  output logic [W-1:0]          rd_data,
  output logic                  rd_valid,
  input  logic                  rd_rel
);

  localparam int HAW = N_LOG - 1;

  // Handshake: a beat is taken on any cycle with in_en=1 and in_rdy=1; a beat
  // offered while in_rdy=0 is dropped and latches ovf. Reads are taken when
  // rd_en=1 and rd_avail=1 and answered with rd_valid exactly one cycle later.

  logic [HAW-1:0] k_q, k_d;
  bank_state_t    bank_st_q [2];
  bank_state_t    bank_st_d [2];
  logic           wr_ptr_q, wr_ptr_d;
  logic           rd_ptr_q, rd_ptr_d;
  logic           in_rdy_q, in_rdy_d;
  logic           frm_done_q, frm_done_d;
  logic           ovf_q, ovf_d;
  logic           rd_valid_q, rd_valid_d;
  logic           rd_bank_q, rd_bank_d;
  logic           rd_half_q, rd_half_d;

  logic           accept;
  logic           last_beat;
  logic           rel;
  logic           rd_acc;
  logic           rd_half_sel;
  logic [HAW-1:0] rd_ram_addr;
  logic [HAW-1:0] wr_addr;
  logic [1:0]     wr_en_bank;
  logic [W-1:0]   ram_rdata [2][2];

  assign rd_avail  = (bank_st_q[rd_ptr_q] == FULL);
  assign accept    = in_en & in_rdy_q;
  assign last_beat = &k_q;
  assign rel       = rd_rel & rd_avail;
  assign rd_acc    = rd_en & rd_avail;

  // Bit-reversed pipelines land beat k at half-address bitrev(k); the MSB of
  // the natural index picks the half. Identity order interleaves on the LSB.
  assign wr_addr     = (BITREV != 0) ? HAW'(bitrev(16'(k_q), HAW)) : k_q;
  assign rd_half_sel = (BITREV != 0) ? rd_addr[N_LOG-1] : rd_addr[0];
  assign rd_ram_addr = (BITREV != 0) ? rd_addr[N_LOG-2:0] : rd_addr[N_LOG-1:1];

  always_comb begin
    k_d        = k_q;
    bank_st_d  = bank_st_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    ovf_d      = ovf_q | (in_en & ~in_rdy_q);
    frm_done_d = accept & last_beat;
    rd_valid_d = rd_acc;
    rd_bank_d  = rd_bank_q;
    rd_half_d  = rd_half_q;
    wr_en_bank = 2'b00;

    if (accept) begin
      wr_en_bank[wr_ptr_q] = 1'b1;
      if (last_beat) begin
        bank_st_d[wr_ptr_q] = FULL;
        k_d                 = '0;
        wr_ptr_d            = ~wr_ptr_q;
      end else begin
        bank_st_d[wr_ptr_q] = FILLING;
        k_d                 = k_q + HAW'(1);
      end
    end

    // A release only ever targets a FULL bank, and the write bank is never
    // FULL while accepting, so both updates can land on the same edge.
    if (rel) begin
      bank_st_d[rd_ptr_q] = EMPTY;
      rd_ptr_d            = ~rd_ptr_q;
    end

    if (rd_acc) begin
      rd_bank_d = rd_ptr_q;
      rd_half_d = rd_half_sel;
    end

    in_rdy_d = (bank_st_d[wr_ptr_d] != FULL);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      k_q        <= '0;
      bank_st_q  <= '{EMPTY, EMPTY};
      wr_ptr_q   <= 1'b0;
      rd_ptr_q   <= 1'b0;
      in_rdy_q   <= 1'b0;
      frm_done_q <= 1'b0;
      ovf_q      <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_bank_q  <= 1'b0;
      rd_half_q  <= 1'b0;
    end else begin
      k_q        <= k_d;
      bank_st_q  <= bank_st_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      in_rdy_q   <= in_rdy_d;
      frm_done_q <= frm_done_d;
      ovf_q      <= ovf_d;
      rd_valid_q <= rd_valid_d;
      rd_bank_q  <= rd_bank_d;
      rd_half_q  <= rd_half_d;
    end
  end

  for (genvar b = 0; b < 2; b++) begin : g_bank
    for (genvar h = 0; h < 2; h++) begin : g_half
      ntt_out_collector_coef_ram #(
        .AW (HAW),
        .W  (W)
      ) u_ram (
        .clk   (clk),
        .rst   (rst),
        .we    (wr_en_bank[b]),
        .waddr (wr_addr),
        .wdata (in[h]),
        .re    (rd_acc),
        .raddr (rd_ram_addr),
        .rdata (ram_rdata[b][h])
      );
    end
  end

  assign rd_data  = ram_rdata[rd_bank_q][rd_half_q];
  assign in_rdy   = in_rdy_q;
  assign frm_done = frm_done_q;
  assign ovf      = ovf_q;
  assign rd_valid = rd_valid_q;

endmodule

// File: tb/tb_ntt_out_collector.sv
// Directed bench for ntt_out_collector: a bit-reversed instance and an
// identity-order instance checked against a read-data expected queue.
module tb_ntt_out_collector;
  import ntt_out_collector_pkg::*;

  localparam int N_LOG = 8;
  localparam int W     = 12;
  localparam int NB    = FRAME_BEATS;
  localparam int NC    = 2 * FRAME_BEATS;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  // bit-reversed instance
  logic              in_en, in_rdy, frm_done, ovf, rd_avail, rd_en, rd_valid, rd_rel;
  logic [1:0][W-1:0] in_d;
  logic [N_LOG-1:0]  rd_addr;
  logic [W-1:0]      rd_data;

  // identity-order instance
  logic              in_en_z, in_rdy_z, frm_done_z, ovf_z, rd_avail_z, rd_en_z, rd_valid_z, rd_rel_z;
  logic [1:0][W-1:0] in_d_z;
  logic [N_LOG-1:0]  rd_addr_z;
  logic [W-1:0]      rd_data_z;

  ntt_out_collector #(.N_LOG(N_LOG), .W(W), .BITREV(1)) dut (
    .clk(clk), .rst(rst), .in_en(in_en), .in(in_d), .in_rdy(in_rdy),
    .frm_done(frm_done), .ovf(ovf), .rd_avail(rd_avail), .rd_en(rd_en),
    .rd_addr(rd_addr), .rd_data(rd_data), .rd_valid(rd_valid), .rd_rel(rd_rel)
  );

  ntt_out_collector #(.N_LOG(N_LOG), .W(W), .BITREV(0)) dut_z (
    .clk(clk), .rst(rst), .in_en(in_en_z), .in(in_d_z), .in_rdy(in_rdy_z),
    .frm_done(frm_done_z), .ovf(ovf_z), .rd_avail(rd_avail_z), .rd_en(rd_en_z),
    .rd_addr(rd_addr_z), .rd_data(rd_data_z), .rd_valid(rd_valid_z), .rd_rel(rd_rel_z)
  );

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  logic [W-1:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int bitrev8(input int x);
    int r;
    r = 0;
    for (int i = 0; i < 8; i++)
      if (((x >> i) & 1) == 1) r = r | (1 << (7 - i));
    return r;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input int base, input bit gap, input bit rel_last);
    int early;
    early = 0;
    for (int k = 0; k < NB; k++) begin
      in_en   = 1'b1;
      in_d[0] = W'(base + 2 * k);
      in_d[1] = W'(base + 2 * k + 1);
      if (rel_last && k == NB - 1) rd_rel = 1'b1;
      cycle();
      in_en  = 1'b0;
      rd_rel = 1'b0;
      if (k == NB - 1) check("frm_done_last_beat", 32'(frm_done), 1);
      else if (frm_done) early++;
      if (gap) begin
        cycle();
        if (k != NB - 1 && frm_done) early++;
      end
    end
    check("frm_done_early", 32'(early), 0);
    if (!gap) cycle();
    check("frm_done_one_cycle", 32'(frm_done), 0);
  endtask

  task automatic drain_check(input string tag, input logic [W-1:0] held);
    rd_en = 1'b0;
    cycle();
    check({tag, "_valid_drop"}, 32'(rd_valid), 0);
    check({tag, "_data_held"}, 32'(rd_data), 32'(held));
    check({tag, "_queue_empty"}, 32'(exp_q.size()), 0);
    exp_q.delete();
  endtask

  task automatic read_frame(input string tag, input int base);
    for (int j = 0; j < NC; j++) begin
      rd_en   = 1'b1;
      rd_addr = N_LOG'(j);
      exp_q.push_back(W'(bitrev8(j) + base));
      cycle();
      check({tag, "_valid"}, 32'(rd_valid), 1);
      if (rd_valid && exp_q.size() != 0) check({tag, "_data"}, 32'(rd_data), 32'(exp_q.pop_front()));
    end
    drain_check(tag, W'(bitrev8(NC - 1) + base));
  endtask

  task automatic release_bank();
    rd_rel = 1'b1;
    cycle();
    rd_rel = 1'b0;
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    rst = 1'b1;
    in_en = 1'b0; in_d = '0; rd_en = 1'b0; rd_addr = '0; rd_rel = 1'b0;
    in_en_z = 1'b0; in_d_z = '0; rd_en_z = 1'b0; rd_addr_z = '0; rd_rel_z = 1'b0;
    repeat (3) cycle();

    check("rst_in_rdy", 32'(in_rdy), 0);
    check("rst_frm_done", 32'(frm_done), 0);
    check("rst_ovf", 32'(ovf), 0);
    check("rst_rd_avail", 32'(rd_avail), 0);
    check("rst_rd_valid", 32'(rd_valid), 0);
    check("rst_rd_data", 32'(rd_data), 0);
    check("rst_z_in_rdy", 32'(in_rdy_z), 0);

    rst = 1'b0;
    cycle();
    check("post_rst_in_rdy", 32'(in_rdy), 1);
    check("post_rst_rd_avail", 32'(rd_avail), 0);

    // Read with nothing buffered is ignored.
    rd_en = 1'b1; rd_addr = 8'd5;
    cycle();
    rd_en = 1'b0;
    check("rd_no_avail_valid", 32'(rd_valid), 0);

    // Frame A: continuous stream.
    send_frame(0, 1'b0, 1'b0);
    check("a_rd_avail", 32'(rd_avail), 1);
    check("a_in_rdy", 32'(in_rdy), 1);
    read_frame("a", 0);
    release_bank();
    check("a_rel_rd_avail", 32'(rd_avail), 0);
    check("a_rel_in_rdy", 32'(in_rdy), 1);

    // Frame B: in_en toggling every other cycle.
    send_frame('h100, 1'b1, 1'b0);
    check("b_rd_avail", 32'(rd_avail), 1);
    read_frame("b", 'h100);
    release_bank();
    check("b_rel_rd_avail", 32'(rd_avail), 0);

    // Two frames without release fill both banks; a third frame's beat drops.
    send_frame('h200, 1'b0, 1'b0);
    check("f1_in_rdy", 32'(in_rdy), 1);
    send_frame('h300, 1'b0, 1'b0);
    check("f2_in_rdy_low", 32'(in_rdy), 0);
    check("f2_ovf_clear", 32'(ovf), 0);
    in_en = 1'b1; in_d[0] = W'('h400); in_d[1] = W'('h401);
    cycle();
    in_en = 1'b0;
    check("f3_ovf_set", 32'(ovf), 1);
    check("f3_in_rdy_low", 32'(in_rdy), 0);
    check("f3_no_frm_done", 32'(frm_done), 0);
    read_frame("f1", 'h200);
    release_bank();
    check("f1_rel_rd_avail", 32'(rd_avail), 1);
    check("f1_rel_in_rdy", 32'(in_rdy), 1);
    read_frame("f2", 'h300);

    // Release of the old bank on the last-beat cycle of the next frame.
    send_frame('h500, 1'b0, 1'b1);
    check("f4_in_rdy", 32'(in_rdy), 1);
    check("f4_rd_avail", 32'(rd_avail), 1);
    check("f4_ovf_sticky", 32'(ovf), 1);
    read_frame("f4", 'h500);

    // Reset in the middle of a frame.
    for (int k = 0; k < 60; k++) begin
      in_en = 1'b1; in_d[0] = W'('h600 + 2 * k); in_d[1] = W'('h601 + 2 * k);
      cycle();
    end
    rst = 1'b1;
    cycle();
    check("mid_rst_in_rdy", 32'(in_rdy), 0);
    check("mid_rst_frm_done", 32'(frm_done), 0);
    check("mid_rst_ovf", 32'(ovf), 0);
    check("mid_rst_rd_avail", 32'(rd_avail), 0);
    check("mid_rst_rd_valid", 32'(rd_valid), 0);
    check("mid_rst_rd_data", 32'(rd_data), 0);
    rst = 1'b0; in_en = 1'b0;
    cycle();
    check("mid_rst_in_rdy_back", 32'(in_rdy), 1);
    send_frame('h700, 1'b0, 1'b0);
    check("after_rst_rd_avail", 32'(rd_avail), 1);
    read_frame("after_rst", 'h700);

    // Identity-order instance: even addresses from lane 0, odd from lane 1.
    for (int k = 0; k < NB; k++) begin
      in_en_z = 1'b1; in_d_z[0] = W'(k); in_d_z[1] = W'(k + 100);
      cycle();
      if (k == NB - 1) check("z_frm_done", 32'(frm_done_z), 1);
    end
    in_en_z = 1'b0;
    cycle();
    check("z_rd_avail", 32'(rd_avail_z), 1);
    for (int n = 0; n < NC; n++) begin
      rd_en_z   = 1'b1;
      rd_addr_z = N_LOG'(n);
      exp_q.push_back(((n & 1) == 0) ? W'(n / 2) : W'(n / 2 + 100));
      cycle();
      check("z_valid", 32'(rd_valid_z), 1);
      if (rd_valid_z && exp_q.size() != 0) check("z_data", 32'(rd_data_z), 32'(exp_q.pop_front()));
    end
    rd_en_z = 1'b0;
    cycle();
    check("z_valid_drop", 32'(rd_valid_z), 0);
    check("z_queue_empty", 32'(exp_q.size()), 0);

    // ---------------- report ----------------
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish (observed timeout, expected completion)");
    $fatal(1, "timeout");
  end

endmodule
